// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the RV32M multiply/divide unit.
// op_t values are the funct3 encodings, so the raw field can be cast directly.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   function automatic logic is_div(op_t op);
      return op[2];
   endfunction

   function automatic logic is_rem(op_t op);
      return op[2] & op[1];
   endfunction

   function automatic logic is_mul_hi(op_t op);
      return !op[2] && (op != OP_MUL);
   endfunction

   function automatic logic a_signed(op_t op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_signed(op_t op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: absolute value of a signed operand on
// the way in, sign restoration of a magnitude result on the way out. Combinational.
module muldiv_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res
);

   assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div, one bit per cycle; XLEN+2 edges from accept to done, 2 for special cases.
// Optional MULDIV_FAST_MUL_EN: multiplies skip CALC via a combinational multiplier. start ignored while busy.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_nx;
   op_t               op_r;
   logic [XLEN-1:0]   opnd_a, opnd_b, spec_val;
   logic [2*XLEN-1:0] prod;
   logic              neg_r, spec_r;
   logic [CW-1:0]     cnt;

   // Accept-side decode
   op_t             op_in;
   logic            sa, sb, accept, div_zero, ovf, special, skip_calc, neg_in;
   logic [XLEN-1:0] abs_a, abs_b, spec_in;

   assign op_in    = op_t'(op);
   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign sa       = a_signed(op_in) & a[XLEN-1];
   assign sb       = b_signed(op_in) & b[XLEN-1];
   assign div_zero = is_div(op_in) && (b == '0);
   assign ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) && (a == INT_MIN) && (b == '1);
   assign special  = div_zero || ovf;
   assign neg_in   = is_rem(op_in) ? sa : (sa ^ sb);

   always_comb begin
      spec_in = '0;
      if (div_zero)
         spec_in = op_in[1] ? a : '1;
      else if (op_in == OP_DIV)
         spec_in = a;
   end

`ifdef MULDIV_FAST_MUL_EN
   assign skip_calc = special || !is_div(op_in);
`else
   assign skip_calc = special;
`endif

   muldiv_signfix #(.W(XLEN)) u_abs_a (.val(a), .neg(sa), .res(abs_a));
   muldiv_signfix #(.W(XLEN)) u_abs_b (.val(b), .neg(sb), .res(abs_b));

   // One shift-add multiply step: multiplier sits in the low half and drains out the bottom.
   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] mul_nx;
   assign add_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd_a} : '0);
   assign mul_nx  = {add_sum, prod[XLEN-1:1]};

   // One restoring divide step: remainder in the high half, dividend/quotient in the low half.
   logic [XLEN:0]     shifted;
   logic              ge;
   logic [XLEN-1:0]   new_rem;
   logic [2*XLEN-1:0] div_nx;
   assign shifted = prod[2*XLEN-1:XLEN-1];
   assign ge      = shifted >= {1'b0, opnd_b};
   assign new_rem = ge ? (shifted[XLEN-1:0] - opnd_b) : shifted[XLEN-1:0];
   assign div_nx  = {new_rem, prod[XLEN-2:0], ge};

   // Output path: division fields are zero-extended so one wide negator serves every op.
   logic [2*XLEN-1:0] fix_src, fixed;
   logic [XLEN-1:0]   result_nx;

   always_comb begin
      fix_src = prod;
      if (is_div(op_r))
         fix_src = op_r[1] ? {{XLEN{1'b0}}, prod[2*XLEN-1:XLEN]} : {{XLEN{1'b0}}, prod[XLEN-1:0]};
`ifdef MULDIV_FAST_MUL_EN
      else
         fix_src = {{XLEN{1'b0}}, opnd_a} * {{XLEN{1'b0}}, opnd_b};
`endif
   end

   muldiv_signfix #(.W(2*XLEN)) u_fix (.val(fix_src), .neg(neg_r), .res(fixed));

   assign result_nx = spec_r ? spec_val :
                      is_mul_hi(op_r) ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = accept ? (skip_calc ? FIX : CALC) : IDLE;
         CALC:       if (cnt == LAST) state_nx = FIX;
         FIX:        state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   assign busy = (state == CALC) || (state == FIX);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_r     <= OP_MUL;
         opnd_a   <= '0;
         opnd_b   <= '0;
         spec_val <= '0;
         prod     <= '0;
         neg_r    <= 1'b0;
         spec_r   <= 1'b0;
         cnt      <= '0;
         result   <= '0;
      end else if (accept) begin
         op_r     <= op_in;
         opnd_a   <= abs_a;
         opnd_b   <= abs_b;
         spec_val <= spec_in;
         spec_r   <= special;
         neg_r    <= neg_in;
         cnt      <= '0;
         prod     <= {{XLEN{1'b0}}, is_div(op_in) ? abs_a : abs_b};
      end else if (state == CALC) begin
         cnt  <= cnt + CW'(1);
         prod <= is_div(op_r) ? div_nx : mul_nx;
      end else if (state == FIX) begin
         result <= result_nx;
      end
   end

endmodule
